axis_2_axi_seg_packer: RTL and testbench
========================================

// Module: axis_2_axi_seg_packer
// PURPOSE
//  Converts a wide AXI-Stream (SEG_COUNT*SEG_DATA_W bits) into a segmented
//  MAC-side bus (per-segment ena/sop/eop/err/mty), one output beat per input beat.
//  Successive packets are rotated so each starts in the segment after the previous eop.
//  Sits between the RoCE TX datapath and the 100G/400G segmented MAC TX port.
//  Generalises the fixed 8x128 converter: parametrised geometry, optional rotation,
//  sticky error tracking across the packet, tkeep legality checks.
// PARAMETERS
//  SEG_COUNT   8                     number of segments (power of 2, 2..16)
//  SEG_DATA_W  128                   bits per segment (multiple of 8)
//  SEG_BYTES   SEG_DATA_W/8          bytes per segment (derived, do not override)
//  MTY_W       $clog2(SEG_BYTES)     width of each mty field (derived)
//  ROTATE      1                     1: rotate packets by running offset; 0: every sop in segment 0
// PORTS
//  clk                  in   1                    clock
//  rst                  in   1                    synchronous, active-high reset
//  s_axis_tdata         in   SEG_COUNT*SEG_DATA_W input data, byte 0 at LSB
//  s_axis_tkeep         in   SEG_COUNT*SEG_BYTES  byte enables
//  s_axis_tvalid        in   1                    input valid
//  s_axis_tready        out  1                    input ready (registered)
//  s_axis_tlast         in   1                    last beat of packet
//  s_axis_tuser         in   1                    error marker, any beat
//  m_axis_seg_tdata     out  SEG_COUNT*SEG_DATA_W rotated segment data
//  m_axis_seg_tvalid    out  1                    output valid
//  m_axis_seg_tready    in   1                    output ready
//  m_axis_seg_tuser_ena out  SEG_COUNT            segment carries data
//  m_axis_seg_tuser_sop out  SEG_COUNT            segment starts packet
//  m_axis_seg_tuser_eop out  SEG_COUNT            segment ends packet
//  m_axis_seg_tuser_err out  SEG_COUNT            packet error, only with eop
//  m_axis_seg_tuser_mty out  SEG_COUNT*MTY_W      empty bytes in segment, nonzero only with eop
//  stat_pkt_count       out  32                   packets emitted (see CONFIGURATION)
//  stat_err_count       out  16                   packets emitted with err (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: tready=0 (rises 1 cycle after rst deasserts), tvalid=0, all tuser outputs 0,
//    tdata 0, offset=0, in-packet=0, sticky err=0, stat counters 0.
//  - Latency 1 cycle accept->output; 2-entry skid (output+temp reg), full throughput,
//    no bubbles; tready_next = m_tready | (!temp_valid & (!out_valid | !s_tvalid)).
//  - Output valid/data stable while m_tvalid & !m_tready; each stored beat carries its own offset.
//  - Input segment i -> output segment (i+offset) mod SEG_COUNT; same map for all tuser fields.
//  - sop: input seg 0 of first beat (in-packet=0). Non-last beat: ena all 1s, eop/mty 0.
//  - Last beat: L = index of highest segment with any tkeep bit; ena segs 0..L, eop on seg L,
//    mty[L] = SEG_BYTES - popcount(tkeep seg L); segs >L: ena 0, data forced 0.
//  - Last beat with tkeep all zero: L=0, ena[0]=1, mty=SEG_BYTES-1, err forced 1.
//  - err on eop seg = tuser on any beat of packet | non-last beat tkeep not all-ones
//    | last-beat tkeep not contiguous from byte 0; sticky cleared after eop beat accepted.
//  - Offset (ROTATE=1): on accepted last beat, offset <= (offset+L+1) mod SEG_COUNT
//    (natural wrap, log2 SEG_COUNT bits). ROTATE=0: offset held 0.
//  - Single-beat packet: sop and eop both set in same beat.
//  - rst mid-packet: partial packet discarded, next accepted beat is sop at offset 0.
// CONFIGURATION
//  AXIS2SEG_STATS_EN defined: stat_pkt_count +1 per output eop beat transferred
//    (m_tvalid & m_tready), stat_err_count +1 if that beat's err set; both saturate.
//  Not defined: counters not built, both ports tied to 0.
// TESTING
//  1 Reset, single 1-beat pkt tkeep=all ones, SEG_COUNT=8 -> ena=FF sop=01 eop=80 mty=0, offset->0.
//  2 Pkt A last beat tkeep=0x0007 (3 bytes, L=0), then pkt B 2 beats -> A: eop=01 mty[0]=13;
//    B beat1 sop=02, data seg i on out seg i+1; offset after A =1.
//  3 Three packets ending L=5,L=4,L=6 -> offsets 6,3,2 (wrap mod 8); check rotation each.
//  4 tuser=1 on first beat of 3-beat pkt only -> err only at eop seg on beat 3; next pkt err=0.
//  5 Random m_tready 50% with back-to-back input -> no loss/dup/reorder vs model, tvalid held.
//  6 ROTATE=0, last tkeep all zero -> sop always seg 0, eop=01 ena=01 err=01 mty=15; with
//    AXIS2SEG_STATS_EN stat_pkt_count=1 stat_err_count=1.

Source files
------------

// File: rtl/axis_2_axi_seg_packer.sv
// Wide AXI-Stream to segmented MAC TX bus, rotating each packet to start after the previous eop.
// Optional saturating packet/error statistics are built when AXIS2SEG_STATS_EN is defined.
module axis_2_axi_seg_packer #(
   parameter int SEG_COUNT  = 8,
   parameter int SEG_DATA_W = 128,
   parameter int SEG_BYTES  = SEG_DATA_W/8,
   parameter int MTY_W      = $clog2(SEG_BYTES),
   parameter int ROTATE     = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [SEG_COUNT*SEG_DATA_W-1:0]  s_axis_tdata,
   input  logic [SEG_COUNT*SEG_BYTES-1:0]   s_axis_tkeep,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   input  logic                             s_axis_tlast,
   input  logic                             s_axis_tuser,
   output logic [SEG_COUNT*SEG_DATA_W-1:0]  m_axis_seg_tdata,
   output logic                             m_axis_seg_tvalid,
   input  logic                             m_axis_seg_tready,
   output logic [SEG_COUNT-1:0]             m_axis_seg_tuser_ena,
   output logic [SEG_COUNT-1:0]             m_axis_seg_tuser_sop,
   output logic [SEG_COUNT-1:0]             m_axis_seg_tuser_eop,
   output logic [SEG_COUNT-1:0]             m_axis_seg_tuser_err,
   output logic [SEG_COUNT*MTY_W-1:0]       m_axis_seg_tuser_mty,
   output logic [31:0]                      stat_pkt_count,
   output logic [15:0]                      stat_err_count
);

   localparam int DW    = SEG_COUNT*SEG_DATA_W;
   localparam int KW    = SEG_COUNT*SEG_BYTES;
   localparam int OFF_W = $clog2(SEG_COUNT);

   typedef struct packed {
      logic [DW-1:0]              data;
      logic [SEG_COUNT-1:0]       ena;
      logic [SEG_COUNT-1:0]       sop;
      logic [SEG_COUNT-1:0]       eop;
      logic [SEG_COUNT-1:0]       err;
      logic [SEG_COUNT*MTY_W-1:0] mty;
   } beat_t;

   logic [OFF_W-1:0]     offset;
   logic                 in_pkt;
   logic                 sticky;
   logic [OFF_W-1:0]     last_seg;
   logic [SEG_COUNT-1:0] seg_any;
   logic [SEG_BYTES-1:0] last_keep;
   logic [MTY_W:0]       last_cnt;
   logic                 keep_full;
   logic                 keep_zero;
   logic                 keep_contig;
   logic                 pkt_err;
   logic [OFF_W-1:0]     j;
   logic                 seg_en;
   beat_t                in_beat;

   beat_t out_reg;
   beat_t tmp_reg;
   logic  out_valid;
   logic  tmp_valid;
   logic  s_ready_reg;
   logic  ready_early;
   logic  accept;

   always_comb begin
      seg_any  = '0;
      last_seg = '0;
      for (int unsigned i = 0; i < SEG_COUNT; i++) begin
         seg_any[i] = |s_axis_tkeep[i*SEG_BYTES +: SEG_BYTES];
         if (seg_any[i]) last_seg = OFF_W'(i);
      end
      keep_full   = &s_axis_tkeep;
      keep_zero   = ~|s_axis_tkeep;
      // contiguous from byte 0 means tkeep has the form 2^n-1
      keep_contig = ((s_axis_tkeep & (s_axis_tkeep + KW'(1))) == '0);
      last_keep   = s_axis_tkeep[int'(last_seg)*SEG_BYTES +: SEG_BYTES];
      last_cnt    = '0;
      for (int unsigned b = 0; b < SEG_BYTES; b++)
         last_cnt = last_cnt + (MTY_W+1)'(last_keep[b]);
      pkt_err = sticky | s_axis_tuser |
                (s_axis_tlast ? (!keep_contig | keep_zero) : !keep_full);

      in_beat = '0;
      j       = '0;
      seg_en  = 1'b0;
      for (int unsigned i = 0; i < SEG_COUNT; i++) begin
         j      = OFF_W'(i) + offset;
         seg_en = !s_axis_tlast || (OFF_W'(i) <= last_seg);
         in_beat.ena[j] = seg_en;
         if (seg_en)
            in_beat.data[int'(j)*SEG_DATA_W +: SEG_DATA_W] = s_axis_tdata[i*SEG_DATA_W +: SEG_DATA_W];
         if (i == 0) in_beat.sop[j] = !in_pkt;
         if (s_axis_tlast && (OFF_W'(i) == last_seg)) begin
            in_beat.eop[j] = 1'b1;
            in_beat.err[j] = pkt_err;
            in_beat.mty[int'(j)*MTY_W +: MTY_W] = keep_zero ? MTY_W'(SEG_BYTES-1)
                                                            : MTY_W'((MTY_W+1)'(SEG_BYTES) - last_cnt);
         end
      end
   end

   assign accept      = s_axis_tvalid & s_ready_reg;
   assign ready_early = m_axis_seg_tready | (!tmp_valid & (!out_valid | !s_axis_tvalid));

   always_ff @(posedge clk) begin
      if (rst) begin
         s_ready_reg <= 1'b0;
         out_valid   <= 1'b0;
         tmp_valid   <= 1'b0;
         out_reg     <= '0;
         tmp_reg     <= '0;
         offset      <= '0;
         in_pkt      <= 1'b0;
         sticky      <= 1'b0;
      end else begin
         s_ready_reg <= ready_early;
         // skid: temp register only fills while the output is stalled
         if (s_ready_reg) begin
            if (m_axis_seg_tready || !out_valid) begin
               out_valid <= s_axis_tvalid;
               if (s_axis_tvalid) out_reg <= in_beat;
            end else begin
               tmp_valid <= s_axis_tvalid;
               if (s_axis_tvalid) tmp_reg <= in_beat;
            end
         end else if (m_axis_seg_tready) begin
            out_valid <= tmp_valid;
            out_reg   <= tmp_reg;
            tmp_valid <= 1'b0;
         end
         if (accept) begin
            if (s_axis_tlast) begin
               in_pkt <= 1'b0;
               sticky <= 1'b0;
               if (ROTATE != 0) offset <= offset + last_seg + OFF_W'(1);
            end else begin
               in_pkt <= 1'b1;
               sticky <= pkt_err;
            end
         end
      end
   end

   assign s_axis_tready        = s_ready_reg;
   assign m_axis_seg_tvalid    = out_valid;
   assign m_axis_seg_tdata     = out_reg.data;
   assign m_axis_seg_tuser_ena = out_reg.ena;
   assign m_axis_seg_tuser_sop = out_reg.sop;
   assign m_axis_seg_tuser_eop = out_reg.eop;
   assign m_axis_seg_tuser_err = out_reg.err;
   assign m_axis_seg_tuser_mty = out_reg.mty;

`ifdef AXIS2SEG_STATS_EN
   logic [31:0] pkt_cnt;
   logic [15:0] err_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt <= '0;
         err_cnt <= '0;
      end else if (out_valid && m_axis_seg_tready && (|out_reg.eop)) begin
         if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 32'd1;
         if ((|out_reg.err) && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
      end
   end

   assign stat_pkt_count = pkt_cnt;
   assign stat_err_count = err_cnt;
`else
   assign stat_pkt_count = '0;
   assign stat_err_count = '0;
`endif

endmodule

// File: tb/tb_axis_2_axi_seg_packer.sv
// Scoreboard bench for axis_2_axi_seg_packer: rotating instance plus a ROTATE=0 instance.
module tb_axis_2_axi_seg_packer;

   localparam int SC = 8, SW = 128, SB = 16, MW = 4;
   localparam int DW = SC*SW, KW = SC*SB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [DW-1:0]    s_tdata;
   logic [KW-1:0]    s_tkeep;
   logic             s_tvalid, s_tready, s_tlast, s_tuser;
   logic [DW-1:0]    m_tdata;
   logic             m_tvalid, m_tready;
   logic [SC-1:0]    m_ena, m_sop, m_eop, m_err;
   logic [SC*MW-1:0] m_mty;
   logic [31:0]      pkt_cnt;
   logic [15:0]      err_cnt;

   logic [DW-1:0]    r_tdata;
   logic [KW-1:0]    r_tkeep;
   logic             r_tvalid, r_tready, r_tlast, r_tuser;
   logic [DW-1:0]    r_m_tdata;
   logic             r_m_tvalid, r_m_tready;
   logic [SC-1:0]    r_ena, r_sop, r_eop, r_err;
   logic [SC*MW-1:0] r_mty;
   logic [31:0]      r_pkt_cnt;
   logic [15:0]      r_err_cnt;

   axis_2_axi_seg_packer #(.SEG_COUNT(SC), .SEG_DATA_W(SW), .ROTATE(1)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_seg_tdata(m_tdata), .m_axis_seg_tvalid(m_tvalid), .m_axis_seg_tready(m_tready),
      .m_axis_seg_tuser_ena(m_ena), .m_axis_seg_tuser_sop(m_sop), .m_axis_seg_tuser_eop(m_eop),
      .m_axis_seg_tuser_err(m_err), .m_axis_seg_tuser_mty(m_mty),
      .stat_pkt_count(pkt_cnt), .stat_err_count(err_cnt)
   );

   axis_2_axi_seg_packer #(.SEG_COUNT(SC), .SEG_DATA_W(SW), .ROTATE(0)) dut_norot (
      .clk(clk), .rst(rst),
      .s_axis_tdata(r_tdata), .s_axis_tkeep(r_tkeep), .s_axis_tvalid(r_tvalid),
      .s_axis_tready(r_tready), .s_axis_tlast(r_tlast), .s_axis_tuser(r_tuser),
      .m_axis_seg_tdata(r_m_tdata), .m_axis_seg_tvalid(r_m_tvalid), .m_axis_seg_tready(r_m_tready),
      .m_axis_seg_tuser_ena(r_ena), .m_axis_seg_tuser_sop(r_sop), .m_axis_seg_tuser_eop(r_eop),
      .m_axis_seg_tuser_err(r_err), .m_axis_seg_tuser_mty(r_mty),
      .stat_pkt_count(r_pkt_cnt), .stat_err_count(r_err_cnt)
   );

   typedef struct {
      logic [DW-1:0]    data;
      logic [SC-1:0]    ena, sop, eop, err;
      logic [SC*MW-1:0] mty;
   } exp_t;

   exp_t sb[$];
   int   m_off = 0;
   bit   m_inpkt = 0, m_sticky = 0;
   int   exp_pkts = 0, exp_errs = 0;
   bit   rand_ready = 0;
   int   checks = 0, passes = 0, fails = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
      checks++;
      assert (got === want) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [KW-1:0] rand_keep();
      logic [KW-1:0] k;
      for (int i = 0; i < KW/32; i++) k[i*32 +: 32] = $urandom;
      return k;
   endfunction

   // Reference model for the rotating instance: one expected output beat per input beat.
   function automatic void model_push(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                      input bit last, input bit user);
      exp_t e;
      int   L, cnt, o;
      bit   zero, full, contig, gap, err;
      e.data = '0; e.ena = '0; e.sop = '0; e.eop = '0; e.err = '0; e.mty = '0;
      zero = (k == '0);
      full = (k == '1);
      contig = 1; gap = 0;
      for (int b = 0; b < KW; b++) begin
         if (!k[b]) gap = 1;
         else if (gap) contig = 0;
      end
      L = 0;
      for (int s = 0; s < SC; s++) if (k[s*SB +: SB] != '0) L = s;
      err = m_sticky | user | (last ? (zero | !contig) : !full);
      for (int s = 0; s < SC; s++) begin
         o = (s + m_off) % SC;
         if (!last || s <= L) begin
            e.ena[o] = 1'b1;
            e.data[o*SW +: SW] = d[s*SW +: SW];
         end
         if (s == 0 && !m_inpkt) e.sop[o] = 1'b1;
         if (last && s == L) begin
            cnt = 0;
            for (int b = 0; b < SB; b++) cnt += int'(k[s*SB+b]);
            e.eop[o] = 1'b1;
            e.err[o] = err;
            e.mty[o*MW +: MW] = zero ? MW'(SB-1) : MW'(SB-cnt);
         end
      end
      if (last) begin
         m_off = (m_off + L + 1) % SC;
         m_inpkt = 0; m_sticky = 0;
      end else begin
         m_inpkt = 1; m_sticky = err;
      end
      sb.push_back(e);
   endfunction

   exp_t mon_e;
   bit   stalled = 0;
   always @(negedge clk) begin
      if (rst) stalled = 0;
      else begin
         if (stalled) chk("hold_valid", 128'(m_tvalid), 128'd1);
         if (m_tvalid && m_tready) begin
            if (sb.size() == 0) chk("unexpected_beat", 128'd1, 128'd0);
            else begin
               mon_e = sb.pop_front();
               chk("sb_ena", 128'(m_ena), 128'(mon_e.ena));
               chk("sb_sop", 128'(m_sop), 128'(mon_e.sop));
               chk("sb_eop", 128'(m_eop), 128'(mon_e.eop));
               chk("sb_err", 128'(m_err), 128'(mon_e.err));
               chk("sb_mty", 128'(m_mty), 128'(mon_e.mty));
               for (int s = 0; s < SC; s++)
                  chk($sformatf("sb_data_seg%0d", s), m_tdata[s*SW +: SW], mon_e.data[s*SW +: SW]);
               if (|mon_e.eop) exp_pkts++;
               if (|mon_e.err) exp_errs++;
            end
         end
         stalled = m_tvalid && !m_tready;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit last, input bit user);
      bit acc;
      int n;
      n = 0;
      s_tdata = d; s_tkeep = k; s_tlast = last; s_tuser = user; s_tvalid = 1'b1;
      model_push(d, k, last, user);
      do begin
         @(negedge clk);
         acc = s_tready;
         tick();
         n++;
      end while (!acc && n < 500);
      if (!acc) chk("accept_timeout", 128'd0, 128'd1);
      s_tvalid = 1'b0;
   endtask

   task automatic rsend(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit last, input bit user);
      bit acc;
      int n;
      n = 0;
      r_tdata = d; r_tkeep = k; r_tlast = last; r_tuser = user; r_tvalid = 1'b1;
      do begin
         @(negedge clk);
         acc = r_tready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 50);
      chk("r_accept", 128'(acc), 128'd1);
      r_tvalid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] ena, input logic [7:0] sop,
                             input logic [7:0] eop, input logic [7:0] err, input logic [31:0] mty);
      int n;
      n = 0;
      @(negedge clk);
      while (!m_tvalid && n < 20) begin @(negedge clk); n++; end
      chk({tag, "_valid"}, 128'(m_tvalid), 128'd1);
      chk({tag, "_ena"}, 128'(m_ena), 128'(ena));
      chk({tag, "_sop"}, 128'(m_sop), 128'(sop));
      chk({tag, "_eop"}, 128'(m_eop), 128'(eop));
      chk({tag, "_err"}, 128'(m_err), 128'(err));
      chk({tag, "_mty"}, 128'(m_mty), 128'(mty));
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin tick(); n++; end
      chk("drain_left", 128'(sb.size()), 128'd0);
      rand_ready = 0;
      tick(); tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; s_tvalid = 1'b0; r_tvalid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tready", 128'(s_tready), 128'd0);
      chk("rst_tvalid", 128'(m_tvalid), 128'd0);
      chk("rst_ena", 128'(m_ena), 128'd0);
      chk("rst_sop", 128'(m_sop), 128'd0);
      chk("rst_eop", 128'(m_eop), 128'd0);
      chk("rst_err", 128'(m_err), 128'd0);
      chk("rst_mty", 128'(m_mty), 128'd0);
      chk("rst_data", 128'(|m_tdata), 128'd0);
      chk("rst_stat_pkt", 128'(pkt_cnt), 128'd0);
      chk("rst_stat_err", 128'(err_cnt), 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_off = 0; m_inpkt = 0; m_sticky = 0; exp_pkts = 0; exp_errs = 0;
      sb.delete();
      @(negedge clk);
      chk("tready_still_low", 128'(s_tready), 128'd0);
      @(negedge clk);
      chk("tready_rise", 128'(s_tready), 128'd1);
      @(posedge clk); #1;
   endtask

   task automatic random_phase();
      int            nb, nby;
      bit            last;
      logic [KW-1:0] k;
      rand_ready = 1;
      for (int p = 0; p < 16; p++) begin
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            last = (b == nb - 1);
            if (!last) k = ($urandom_range(0, 7) == 0) ? rand_keep() : '1;
            else begin
               nby = $urandom_range(0, KW);
               k = (nby == 0) ? '0 : ({KW{1'b1}} >> (KW - nby));
               if ($urandom_range(0, 5) == 0) k = rand_keep();
            end
            send(rand_data(), k, last, ($urandom_range(0, 9) == 0));
         end
      end
      drain();
   endtask

   logic [DW-1:0] d6;

   initial begin
      s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
      r_tdata = '0; r_tkeep = '0; r_tvalid = 1'b0; r_tlast = 1'b0; r_tuser = 1'b0;
      m_tready = 1'b1; r_m_tready = 1'b1;
      do_reset();

      // single full beat at offset 0
      send(rand_data(), '1, 1, 0);
      expect_out("t1", 8'hFF, 8'h01, 8'h80, 8'h00, 32'h0);

      // 3-byte packet then 2-beat packet rotated by one segment
      send(rand_data(), KW'(128'h7), 1, 0);
      expect_out("t2a", 8'h01, 8'h01, 8'h01, 8'h00, 32'h0000000D);
      send(rand_data(), '1, 0, 0);
      expect_out("t2b1", 8'hFF, 8'h02, 8'h00, 8'h00, 32'h0);
      send(rand_data(), '1, 1, 0);
      expect_out("t2b2", 8'hFF, 8'h00, 8'h01, 8'h00, 32'h0);

      // reset in the middle of a packet restarts at offset 0 with sop
      send(rand_data(), '1, 0, 0);
      expect_out("mid", 8'hFF, 8'h02, 8'h00, 8'h00, 32'h0);
      do_reset();
      send(rand_data(), '1, 1, 0);
      expect_out("post_rst", 8'hFF, 8'h01, 8'h80, 8'h00, 32'h0);

      // ends at L=5, L=4, L=6 give offsets 6, 3, 2
      send(rand_data(), {KW{1'b1}} >> 32, 1, 0);
      expect_out("t3_l5", 8'h3F, 8'h01, 8'h20, 8'h00, 32'h0);
      send(rand_data(), {KW{1'b1}} >> 48, 1, 0);
      expect_out("t3_l4", 8'hC7, 8'h40, 8'h04, 8'h00, 32'h0);
      send(rand_data(), {KW{1'b1}} >> 16, 1, 0);
      expect_out("t3_l6", 8'hFB, 8'h08, 8'h02, 8'h00, 32'h0);
      send(rand_data(), '1, 1, 0);
      expect_out("t3_off2", 8'hFF, 8'h04, 8'h02, 8'h00, 32'h0);

      // tuser on first beat only is reported at eop; next packet is clean
      send(rand_data(), '1, 0, 1);
      expect_out("t4_b1", 8'hFF, 8'h04, 8'h00, 8'h00, 32'h0);
      send(rand_data(), '1, 0, 0);
      expect_out("t4_b2", 8'hFF, 8'h00, 8'h00, 8'h00, 32'h0);
      send(rand_data(), '1, 1, 0);
      expect_out("t4_b3", 8'hFF, 8'h00, 8'h02, 8'h02, 32'h0);
      send(rand_data(), '1, 1, 0);
      expect_out("t4_next", 8'hFF, 8'h04, 8'h02, 8'h00, 32'h0);
      send(rand_data(), KW'(128'h5), 1, 0);
      expect_out("noncontig", 8'h04, 8'h04, 8'h04, 8'h04, 32'h00000E00);

      // back-to-back traffic with random output backpressure
      random_phase();

`ifdef AXIS2SEG_STATS_EN
      chk("stat_pkt", 128'(pkt_cnt), 128'(exp_pkts));
      chk("stat_err", 128'(err_cnt), 128'(exp_errs));
`else
      chk("stat_pkt_tied", 128'(pkt_cnt), 128'd0);
      chk("stat_err_tied", 128'(err_cnt), 128'd0);
`endif

      // ROTATE=0 instance: empty last beat, then a full packet still at seg 0
      d6 = rand_data();
      rsend(d6, '0, 1, 0);
      @(negedge clk);
      chk("r6_valid", 128'(r_m_tvalid), 128'd1);
      chk("r6_sop", 128'(r_sop), 128'h01);
      chk("r6_eop", 128'(r_eop), 128'h01);
      chk("r6_ena", 128'(r_ena), 128'h01);
      chk("r6_err", 128'(r_err), 128'h01);
      chk("r6_mty", 128'(r_mty), 128'h0000000F);
      chk("r6_data_seg0", r_m_tdata[SW-1:0], d6[SW-1:0]);
      chk("r6_data_hi", 128'(|r_m_tdata[DW-1:SW]), 128'd0);
      @(posedge clk); #1;
      @(negedge clk);
`ifdef AXIS2SEG_STATS_EN
      chk("r6_stat_pkt", 128'(r_pkt_cnt), 128'd1);
      chk("r6_stat_err", 128'(r_err_cnt), 128'd1);
`else
      chk("r6_stat_pkt", 128'(r_pkt_cnt), 128'd0);
      chk("r6_stat_err", 128'(r_err_cnt), 128'd0);
`endif
      @(posedge clk); #1;
      rsend(rand_data(), '1, 1, 0);
      @(negedge clk);
      chk("r6b_valid", 128'(r_m_tvalid), 128'd1);
      chk("r6b_sop", 128'(r_sop), 128'h01);
      chk("r6b_eop", 128'(r_eop), 128'h80);
      chk("r6b_err", 128'(r_err), 128'h00);
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
